// File: rtl/mod_addsub_seq_pkg.sv
// Shared encodings for the modular add/sub sequencer and its datapath.
package mod_addsub_seq_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_seq_if.sv
// Request/response port bundle for mod_addsub_seq; master is the host, slave the block.
interface mod_addsub_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic             in_acc;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, in_m, out_ready,
        input  in_ready, out_valid, out_z, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, in_m, out_ready,
        output in_ready, out_valid, out_z, out_err, busy
    );
endinterface

// File: rtl/mod_addsub_dp.sv
// Combinational modular add/sub core: raw sum/difference plus the one-step correction.
module mod_addsub_dp
    import mod_addsub_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             op,
    output logic [WIDTH:0]   raw,
    output logic             first_condition,
    output logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] w
);
    logic [WIDTH:0] a_x, b_x, m_x;

    always_comb begin
        a_x = {1'b0, a};
        b_x = {1'b0, b};
        m_x = {1'b0, m};
        if (op == OP_SUB) begin
            // Borrow out of the extra bit means the difference went negative.
            raw             = a_x - b_x;
            first_condition = raw[WIDTH];
            w               = WIDTH'(raw + m_x);
        end else begin
            raw             = a_x + b_x;
            first_condition = (raw >= m_x);
            w               = WIDTH'(raw - m_x);
        end
        v = raw[WIDTH-1:0];
    end

endmodule

// File: rtl/mod_addsub_seq.sv
// Sequencer around mod_addsub_dp: one op per handshake, operand legality check, chaining accumulator.
module mod_addsub_seq
    import mod_addsub_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mod_addsub_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] M_MIN = WIDTH'(2);

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   raw_q;
    logic             fc_q;
    logic [WIDTH-1:0] w_q;
    logic             err_q;
    logic [WIDTH-1:0] z_q;
    logic             out_err_q;
    logic             out_valid_q;

    logic [WIDTH:0]   dp_raw;
    logic             dp_fc;
    logic [WIDTH-1:0] dp_v, dp_w;
    logic [WIDTH-1:0] z_sel;
    logic             req_err;
    logic             unused_bits;

    mod_addsub_dp #(.WIDTH(WIDTH)) u_dp (
        .a               (a_q),
        .b               (b_q),
        .m               (m_q),
        .op              (op_q),
        .raw             (dp_raw),
        .first_condition (dp_fc),
        .v               (dp_v),
        .w               (dp_w)
    );

    // v is taken from the registered raw value; the top bit only feeds first_condition.
    assign unused_bits = ^{dp_v, raw_q[WIDTH]};

    assign req_err = (m_q < M_MIN) || (a_q >= m_q) || (b_q >= m_q);
    assign z_sel   = fc_q ? w_q : raw_q[WIDTH-1:0];

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = z_q;
    assign bus.out_err   = out_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            raw_q       <= '0;
            fc_q        <= 1'b0;
            w_q         <= '0;
            err_q       <= 1'b0;
            z_q         <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.in_op;
                        a_q   <= bus.in_acc ? acc_q : bus.in_a;
                        b_q   <= bus.in_b;
                        m_q   <= bus.in_m;
                        state <= CALC;
                    end
                end
                CALC: begin
                    raw_q <= dp_raw;
                    fc_q  <= dp_fc;
                    w_q   <= dp_w;
                    err_q <= req_err;
                    state <= CORR;
                end
                CORR: begin
                    // Illegal requests report zero and leave the chain value untouched.
                    if (err_q) begin
                        z_q       <= '0;
                        out_err_q <= 1'b1;
                    end else begin
                        z_q       <= z_sel;
                        acc_q     <= z_sel;
                        out_err_q <= 1'b0;
                    end
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed-vector bench for mod_addsub_seq with hand-computed results.
module tb_mod_addsub_seq;
    import mod_addsub_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mod_addsub_seq_if #(.WIDTH(4)) bus ();

    mod_addsub_seq #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "/in_ready"}, {7'd0, bus.in_ready}, 8'd1);
    endtask

    task automatic drive(input logic op, input logic acc, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] m);
        bus.in_op  = op;
        bus.in_acc = acc;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_m   = m;
    endtask

    // Full transaction with out_ready high: result appears two edges after acceptance.
    task automatic do_op(input string tag, input logic op, input logic acc,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                         input logic [3:0] ez, input logic ee);
        wait_ready(tag);
        drive(op, acc, a, b, m);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "/busy"}, {7'd0, bus.busy}, 8'd1);
        chk({tag, "/early0"}, {7'd0, bus.out_valid}, 8'd0);
        step();
        chk({tag, "/early1"}, {7'd0, bus.out_valid}, 8'd0);
        step();
        chk({tag, "/valid"}, {7'd0, bus.out_valid}, 8'd1);
        chk({tag, "/z"}, {4'd0, bus.out_z}, {4'd0, ez});
        chk({tag, "/err"}, {7'd0, bus.out_err}, {7'd0, ee});
        step();
        chk({tag, "/drop"}, {7'd0, bus.out_valid}, 8'd0);
        chk({tag, "/rdy_back"}, {7'd0, bus.in_ready}, 8'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(OP_ADD, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        step();
        chk("rst/in_ready", {7'd0, bus.in_ready}, 8'd0);
        chk("rst/out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst/out_z", {4'd0, bus.out_z}, 8'd0);
        chk("rst/out_err", {7'd0, bus.out_err}, 8'd0);
        chk("rst/busy", {7'd0, bus.busy}, 8'd0);
        rst = 1'b0;
        #1;
        chk("rst/in_ready_rel", {7'd0, bus.in_ready}, 8'd1);

        // Basic add/sub with m=7
        do_op("add5_4", OP_ADD, 1'b0, 4'd5, 4'd4, 4'd7, 4'd2, 1'b0);
        do_op("sub2_5", OP_SUB, 1'b0, 4'd2, 4'd5, 4'd7, 4'd4, 1'b0);
        do_op("sub5_2", OP_SUB, 1'b0, 4'd5, 4'd2, 4'd7, 4'd3, 1'b0);

        // Accumulator chain with m=13
        do_op("ch_add", OP_ADD, 1'b0, 4'd9, 4'd8, 4'd13, 4'd4, 1'b0);
        do_op("ch_sub", OP_SUB, 1'b1, 4'd15, 4'd6, 4'd13, 4'd11, 1'b0);
        do_op("ch_wrap", OP_ADD, 1'b1, 4'd15, 4'd2, 4'd13, 4'd0, 1'b0);

        // Illegal requests leave the accumulator (0) alone
        do_op("err_a", OP_ADD, 1'b0, 4'd9, 4'd1, 4'd7, 4'd0, 1'b1);
        do_op("err_acc", OP_ADD, 1'b1, 4'd6, 4'd1, 4'd7, 4'd1, 1'b0);
        do_op("err_m1", OP_ADD, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 1'b1);
        do_op("top_edge", OP_ADD, 1'b0, 4'd14, 4'd14, 4'd15, 4'd13, 1'b0);

        // Backpressure: result 1+2=3 held while a second request is ignored
        bus.out_ready = 1'b0;
        wait_ready("bp");
        drive(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd7);
        bus.in_valid = 1'b1;
        step();
        drive(OP_ADD, 1'b0, 4'd6, 4'd6, 4'd7);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp/valid", {7'd0, bus.out_valid}, 8'd1);
            chk("bp/z", {4'd0, bus.out_z}, 8'd3);
            chk("bp/in_ready", {7'd0, bus.in_ready}, 8'd0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp/still", {7'd0, bus.out_valid}, 8'd1);
        step();
        chk("bp/accepted", {7'd0, bus.out_valid}, 8'd0);
        chk("bp/idle", {7'd0, bus.busy}, 8'd0);
        do_op("bp_acc", OP_ADD, 1'b1, 4'd0, 4'd0, 4'd7, 4'd3, 1'b0);

        // Reset while in CORR discards the pending result and clears the accumulator
        wait_ready("mid");
        drive(OP_ADD, 1'b0, 4'd6, 4'd6, 4'd7);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid/out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("mid/busy", {7'd0, bus.busy}, 8'd0);
        chk("mid/in_ready", {7'd0, bus.in_ready}, 8'd1);
        step();
        step();
        chk("mid/no_emit", {7'd0, bus.out_valid}, 8'd0);
        do_op("mid_acc0", OP_ADD, 1'b1, 4'd5, 4'd2, 4'd7, 4'd2, 1'b0);
        do_op("fresh3_3", OP_ADD, 1'b0, 4'd3, 4'd3, 4'd7, 4'd6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
